// File: rtl/poly1305_pkg.sv
// Shared constants and types for the Poly1305 one-time key loader.
// Holds the r clamp mask, key/r widths and the loader state encoding.
package poly1305_pkg;

    localparam int KEY_W = 256;
    localparam int R_W   = 128;

    localparam logic [R_W-1:0] POLY1305_CLAMP_MASK =
        128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } loader_state_e;

endpackage

// File: rtl/poly1305_clamp_mask.sv
// Combinational Poly1305 r clamp: clears the top four bits of every 32-bit
// limb and the low two bits of the upper three limbs.
module poly1305_clamp_mask
    import poly1305_pkg::*;
(
    input  logic [R_W-1:0] r_raw,
    output logic [R_W-1:0] r_clamped
);

    assign r_clamped = r_raw & POLY1305_CLAMP_MASK;

endmodule

// File: rtl/poly1305_key_loader.sv
// Assembles the 256-bit Poly1305 key (r || s) from a word stream, clamps r and
// holds r/s for the MAC core. Optional macro: POLY1305_KEY_ZEROIZE_EN.
module poly1305_key_loader
    import poly1305_pkg::*;
#(
    parameter int WORD_W = 32
)
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [R_W-1:0]    r,
    output logic [R_W-1:0]    s
);

    localparam int WORDS = KEY_W / WORD_W;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

    loader_state_e    state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [KEY_W-1:0] key_reg, key_next;
    logic [R_W-1:0]   r_reg, r_next;
    logic [R_W-1:0]   s_reg, s_next;

    logic [KEY_W-1:0] key_wr;
    logic [R_W-1:0]   r_clamped;

    // key_wr is the key register with the incoming word merged into slot cnt.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_slot
            assign key_wr[gi*WORD_W +: WORD_W] =
                (cnt_reg == CNT_W'(gi)) ? in_data : key_reg[gi*WORD_W +: WORD_W];
        end
    endgenerate

    poly1305_clamp_mask u_clamp (
        .r_raw     (key_wr[R_W-1:0]),
        .r_clamped (r_clamped)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= LOAD;
            cnt_reg   <= '0;
            key_reg   <= '0;
            r_reg     <= '0;
            s_reg     <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            key_reg   <= key_next;
            r_reg     <= r_next;
            s_reg     <= s_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        key_next   = key_reg;
        r_next     = r_reg;
        s_next     = s_reg;
        in_ready   = (state_reg == LOAD);
        out_valid  = (state_reg == HOLD);

        if (flush) begin
            // Flush wins over everything, including a same-cycle out handshake.
            state_next = LOAD;
            cnt_next   = '0;
`ifdef POLY1305_KEY_ZEROIZE_EN
            key_next   = '0;
            r_next     = '0;
            s_next     = '0;
`endif
        end else begin
            case (state_reg)
                LOAD: begin
                    if (in_valid) begin
                        key_next = key_wr;
                        if (cnt_reg == LAST_CNT) begin
                            cnt_next   = '0;
                            state_next = HOLD;
                            r_next     = r_clamped;
                            s_next     = key_wr[KEY_W-1:R_W];
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_next = LOAD;
`ifdef POLY1305_KEY_ZEROIZE_EN
                        key_next   = '0;
                        r_next     = '0;
                        s_next     = '0;
`endif
                    end
                end
                default: begin
                    state_next = LOAD;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign r = r_reg;
    assign s = s_reg;

endmodule

// File: doc/poly1305_key_loader.md
Name: poly1305_key_loader

Overview:
- Collects the 256-bit Poly1305 one-time key (r || s) from a narrow word stream, clamps r, and presents registered r and s to the MAC core over a valid/ready handshake.
- Sits between the ChaCha20 block-0 keystream output and the poly1305 accumulator.
- Generalises the combinational clamp: parametrised input width, sequential word assembly, single-entry output buffer with backpressure, and flush.

Parameters:
- WORD_W, 32, input word width in bits. Legal values: 8, 32, 64, 128, 256; must divide 256.
- WORDS, 256/WORD_W, derived word count. Not overridable.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort; discards partial key and any held output
- in_valid  in  1  input word valid
- in_ready  out  1  loader accepts a word this cycle
- in_data  in  WORD_W  key word; word k maps to key bits [k*WORD_W +: WORD_W] (little-endian, byte 0 in bits [7:0])
- out_valid  out  1  clamped key available
- out_ready  in  1  consumer accepts key
- r  out  128  clamped r
- s  out  128  s (key bits [255:128]), unmodified

Behaviour:
- Interface: one clock `clock`; reset `reset_n` is asynchronous, active-low.
- Reset values: state=LOAD, word count=0, key register=0, out_valid=0, r=0, s=0. in_ready=1 after reset.
- FSM states:
  - LOAD: in_ready=1, out_valid=0. Each in_valid&in_ready writes in_data into word slot cnt and increments cnt. On the handshake where cnt==WORDS-1, go to HOLD and reset cnt to 0.
  - HOLD: in_ready=0, out_valid=1. r and s stay stable until out_valid&out_ready, then go to LOAD.
- in_ready is a pure function of state; it has no combinational dependence on out_ready. After accept, the next word is taken no earlier than the following cycle.
- Latency: out_valid rises the cycle after the final word handshake. Minimum period per key is WORDS+1 cycles.
- Clamp: r = key[127:0] AND 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff. Applied when the final word is stored; r is a registered output.
- WORD_W=256: the single-word case; LOAD→HOLD on every accepted word.
- in_valid while in_ready=0: ignored; data must be held by the source per the valid/ready rule.
- flush: highest priority, takes effect in any state. Next cycle: state=LOAD, cnt=0, out_valid=0. The key register is not cleared unless the optional feature is enabled. A word presented in the same cycle as flush is dropped.
- Simultaneous flush and out_ready in HOLD: treated as flush. The key counts as not delivered.
- reset_n asserted mid-load: all state returns to reset values asynchronously.
- Counter is $clog2(WORDS) bits, minimum 1. It never wraps past WORDS-1.

Optional Feature:
- Macro: POLY1305_KEY_ZEROIZE_EN.
- Defined:
  - The key register, r and s are cleared to 0 on the cycle after an out handshake and on flush.
  - r and s read 0 whenever out_valid=0.
- Undefined: r, s and the key register retain their last value after a handshake or flush (lower power, no clear mux).

Decomposition:
- Package poly1305_pkg:
  - POLY1305_CLAMP_MASK (128-bit constant)
  - KEY_W=256, R_W=128
  - loader state enum {LOAD, HOLD}
- Sub-module poly1305_clamp_mask: combinational 128-bit AND with the package mask, instantiated once on the assembled r.

Test Plan:
- RFC 8439 §2.5.2 key, WORD_W=32, 8 words, out_ready=1 → r=0x0806d5400e52447c036d555408bed685, s=0x1bf54941aff6bf4afdb20dfb8a800301; out_valid exactly 1 cycle after the 8th word.
- Key of all 0xFF, WORD_W=8 → r=0x0ffffffc0ffffffc0ffffffc0fffffff, s=all-ones.
- Backpressure: out_ready=0 for 10 cycles in HOLD, in_valid=1 throughout → in_ready=0, r/s stable, no words consumed. Then out_ready=1 → LOAD next cycle.
- Flush after 3 of 8 words, then a full 8-word load of the RFC key → output equals the RFC vector, with no partial-key bytes present.
- reset_n pulsed low mid-load (4 of 8 words) → out_valid=0, in_ready=1 immediately, cnt=0. The next full load is correct.
- With POLY1305_KEY_ZEROIZE_EN: after the handshake of the RFC key → r=0 and s=0 on the next cycle. Without the macro: previous values held.
